dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the memory-access stage
//  (data port, priority) and instruction fetch. Data loads/stores of byte/half/word
//  width (RISC-V funct3 encoding) are converted to byte enables plus lane
//  replication, and load data is extracted and sign/zero-extended.
//  Fetch is protected from starvation by a counter. Sits between the CPU stages and the memory array.
// PARAMETERS
//  ADDR_W        12  byte-address bits used; memory depth 2**(ADDR_W-2) words; upper bits ignored
//  FETCH_STARVE  4   max consecutive data grants while fetch waits (>=1)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  d_req_valid  in   1        data request valid
//  d_req_ready  out  1        data request accepted this cycle
//  d_addr       in   32       data byte address
//  d_we         in   1        1 = store, 0 = load
//  d_wdata      in   32       store data, right-aligned
//  d_width      in   3        000 b, 001 h, 010 w, 100 bu, 101 hu
//  d_rsp_valid  out  1        data response, 1-cycle pulse
//  d_rdata      out  32       extended load data (0 for stores/errors)
//  d_err        out  1        misaligned or illegal width; qualifies d_rsp_valid
//  f_req_valid  in   1        fetch request valid
//  f_req_ready  out  1        fetch request accepted this cycle
//  f_addr       in   32       fetch address; bits [1:0] ignored
//  f_rsp_valid  out  1        fetch response, 1-cycle pulse
//  f_rdata      out  32       fetched word
//  m_en         out  1        memory access enable
//  m_we         out  1        memory write
//  m_be         out  4        byte enables, bit i = byte lane i (little-endian)
//  m_addr       out  ADDR_W-2 word address
//  m_wdata      out  32       lane-replicated write data
//  m_rdata      in   32       read word, valid cycle after m_en && !m_we
// BEHAVIOUR
//  - Reset: all outputs 0, starvation counter 0, response pipeline cleared.
//    Reset asserted mid-operation drops pending response (no rsp pulse after release).
//  - Grant (combinational, one winner per cycle, readies 0 while rst_n=0):
//    fetch wins if f_req_valid && (!d_req_valid || starve_cnt==FETCH_STARVE);
//    else data wins if d_req_valid. Loser's ready=0; it must hold its request.
//  - starve_cnt: +1 on each data grant while f_req_valid=1 (saturating at FETCH_STARVE);
//    cleared on fetch grant or when f_req_valid=0.
//  - m_* driven combinationally from the granted request in the grant cycle (cycle N);
//    response registered, pulses in N+1. Throughput 1 request/cycle, back-to-back allowed.
//  - Error check (data): width 011/110/111 illegal; half with addr[0]=1 or word with
//    addr[1:0]!=0 misaligned. Erroneous request is still accepted (ready=1), m_en=0,
//    fetch not granted that cycle, starve_cnt unchanged; N+1: d_rsp_valid=1, d_err=1, d_rdata=0.
//  - Store: sb be=1<<addr[1:0], wdata={4{b}}; sh be=addr[1]?1100:0011, wdata={2{h}};
//    sw be=1111. N+1: d_rsp_valid=1, d_err=0, d_rdata=0 (ack). bu/hu widths on store: same as b/h.
//  - Load: m_be=1111; addr[1:0] and width registered at N; N+1 select lane from m_rdata:
//    b/h sign-extend, bu/hu zero-extend, w pass-through.
//  - Fetch: m_we=0, m_be=1111, m_addr=f_addr[ADDR_W-1:2]; N+1 f_rsp_valid=1, f_rdata=m_rdata.
//  - Address wrap: bits above ADDR_W-1 ignored (addr 2**ADDR_W aliases 0).
//  - Response outputs hold last value between pulses, except d_err which is 0 when no pulse.
// TESTING
//  1 sw 0xABCDABCD @4, then lw @4 -> store ack d_err=0; load N+1 d_rdata=ABCDABCD.
//  2 sb 0x80 @9 -> m_be=0010, m_wdata=80808080; lb @9 -> FFFFFF80; lbu @9 -> 00000080.
//  3 sw 0 @4, sh 0x1234 @6 -> m_be=1100; lw @4 -> 12340000; lh @6 -> 00001234.
//  4 lw @6 and d_width=011 @8 -> d_err=1, m_en=0, d_rdata=0; lw @4 unchanged afterwards.
//  5 d_req_valid and f_req_valid held 1 -> grants D D D D F repeating; f_rsp_valid
//    every 5th cycle; with fetch alone -> 1 fetch/cycle, f_rdata=word at f_addr.
//  6 lw issued, rst_n low before next edge -> d_rsp_valid stays 0, readies 0 during reset,
//    starve_cnt 0 after release (fetch waits full FETCH_STARVE again).

Source files
------------

// File: rtl/dmem_arbiter_if.sv
//------------------------------------------------------------------------------
// dmem_arbiter_if : data/fetch request, response and memory-side bus bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if #(
   parameter int ADDR_W = 12
);
   logic              d_req_valid;
   logic              d_req_ready;
   logic [31:0]       d_addr;
   logic              d_we;
   logic [31:0]       d_wdata;
   logic [2:0]        d_width;
   logic              d_rsp_valid;
   logic [31:0]       d_rdata;
   logic              d_err;
   logic              f_req_valid;
   logic              f_req_ready;
   logic [31:0]       f_addr;
   logic              f_rsp_valid;
   logic [31:0]       f_rdata;
   logic              m_en;
   logic              m_we;
   logic [3:0]        m_be;
   logic [ADDR_W-3:0] m_addr;
   logic [31:0]       m_wdata;
   logic [31:0]       m_rdata;

   modport slave (
      input  d_req_valid, d_addr, d_we, d_wdata, d_width, f_req_valid, f_addr, m_rdata,
      output d_req_ready, d_rsp_valid, d_rdata, d_err, f_req_ready, f_rsp_valid, f_rdata,
             m_en, m_we, m_be, m_addr, m_wdata
   );

   modport master (
      output d_req_valid, d_addr, d_we, d_wdata, d_width, f_req_valid, f_addr, m_rdata,
      input  d_req_ready, d_rsp_valid, d_rdata, d_err, f_req_ready, f_rsp_valid, f_rdata,
             m_en, m_we, m_be, m_addr, m_wdata
   );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// dmem_arbiter : single-port memory shared by data port (priority) and fetch
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int FETCH_STARVE = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(FETCH_STARVE + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(FETCH_STARVE);

   logic [CNT_W-1:0] starve_cnt;
   logic             d_illegal, d_misalign, d_bad;
   logic             f_gnt, d_gnt, d_go;
   logic             ld_pend, err_q;
   logic [1:0]       ld_off;
   logic [2:0]       ld_width;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_ext, d_rdata_hold, f_rdata_hold;

   always_comb begin
      d_illegal  = (bus.d_width == 3'b011) || (bus.d_width == 3'b110) || (bus.d_width == 3'b111);
      d_misalign = ((bus.d_width[1:0] == 2'b01) && bus.d_addr[0]) ||
                   ((bus.d_width == 3'b010) && (bus.d_addr[1:0] != 2'b00));
      d_bad      = d_illegal || d_misalign;
      f_gnt      = rst_n && bus.f_req_valid && (!bus.d_req_valid || (starve_cnt == STARVE_MAX));
      d_gnt      = rst_n && bus.d_req_valid && !f_gnt;
      d_go       = d_gnt && !d_bad;
   end

   assign bus.d_req_ready = d_gnt;
   assign bus.f_req_ready = f_gnt;

   // Memory side is driven in the grant cycle; idle cycles present all zeros.
   always_comb begin
      bus.m_en    = f_gnt || d_go;
      bus.m_we    = d_go && bus.d_we;
      bus.m_be    = 4'b0000;
      bus.m_addr  = '0;
      bus.m_wdata = 32'h0;
      if (f_gnt) begin
         bus.m_be   = 4'b1111;
         bus.m_addr = bus.f_addr[ADDR_W-1:2];
      end else if (d_go) begin
         bus.m_addr = bus.d_addr[ADDR_W-1:2];
         bus.m_be   = 4'b1111;
         if (bus.d_we) begin
            case (bus.d_width[1:0])
               2'b00: begin
                  bus.m_be    = 4'b0001 << bus.d_addr[1:0];
                  bus.m_wdata = {4{bus.d_wdata[7:0]}};
               end
               2'b01: begin
                  bus.m_be    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                  bus.m_wdata = {2{bus.d_wdata[15:0]}};
               end
               default: bus.m_wdata = bus.d_wdata;
            endcase
         end
      end
   end

   always_comb begin
      case (ld_off)
         2'b00:   ld_byte = bus.m_rdata[7:0];
         2'b01:   ld_byte = bus.m_rdata[15:8];
         2'b10:   ld_byte = bus.m_rdata[23:16];
         default: ld_byte = bus.m_rdata[31:24];
      endcase
      ld_half = ld_off[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
      case (ld_width)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'h0, ld_byte};
         3'b101:  ld_ext = {16'h0, ld_half};
         default: ld_ext = bus.m_rdata;
      endcase
   end

   // Read data only exists in the pulse cycle; the hold registers keep it afterwards.
   assign bus.d_rdata = bus.d_rsp_valid ? (ld_pend ? ld_ext : 32'h0) : d_rdata_hold;
   assign bus.f_rdata = bus.f_rsp_valid ? bus.m_rdata : f_rdata_hold;
   assign bus.d_err   = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt      <= '0;
         bus.d_rsp_valid <= 1'b0;
         bus.f_rsp_valid <= 1'b0;
         err_q           <= 1'b0;
         ld_pend         <= 1'b0;
         ld_off          <= 2'b00;
         ld_width        <= 3'b000;
         d_rdata_hold    <= 32'h0;
         f_rdata_hold    <= 32'h0;
      end else begin
         if (f_gnt || !bus.f_req_valid) begin
            starve_cnt <= '0;
         end else if (d_go && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
         bus.d_rsp_valid <= d_gnt;
         bus.f_rsp_valid <= f_gnt;
         err_q           <= d_gnt && d_bad;
         ld_pend         <= d_go && !bus.d_we;
         ld_off          <= bus.d_addr[1:0];
         ld_width        <= bus.d_width;
         d_rdata_hold    <= bus.d_rdata;
         f_rdata_hold    <= bus.f_rdata;
      end
   end
endmodule

`default_nettype wire
